// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and defaults for the UART TX scheduler.
// Consumers import sc64::* for the FSM state enum and the pointer helper.
package sc64;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_GAP   = 2'd2
   } e_tx_sched_state;

   localparam int UART_SCHED_NUM_REQ   = 4;
   localparam int UART_SCHED_MAX_BURST = 16;

   // Next round-robin start; index 0 is reserved for the priority port when prio_en is set.
   function automatic logic [2:0] rr_next_ptr(input logic [2:0] cur,
                                              input logic [3:0] n_req,
                                              input logic       prio_en);
      logic [3:0] nxt;
      nxt = {1'b0, cur} + 4'd1;
      if (nxt >= n_req) begin
         nxt = prio_en ? 4'd1 : 4'd0;
      end else begin
         nxt = nxt;
      end
      return nxt[2:0];
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_arbiter.sv
// Combinational round-robin winner search over the requester valid vector.
// With prio_en_i set, requester 0 always wins and the rotation covers 1..NUM_REQ-1.
module uart_rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [2:0]         rr_ptr_i,
   input  logic               prio_en_i,
   output logic [2:0]         winner_o,
   output logic               any_valid_o
);

   localparam logic [3:0] N_REQ = 4'(NUM_REQ);

   // Scan upward from the pointer, wrapping, and keep the first valid index.
   always_comb begin : pick
      logic [3:0] base;
      logic [3:0] idx;
      logic       hit;
      logic       found;
      winner_o    = 3'd0;
      any_valid_o = |valid_i;
      idx         = 4'd0;
      hit         = 1'b0;
      if (prio_en_i && (rr_ptr_i == 3'd0)) begin
         base = 4'd1;
      end else begin
         base = {1'b0, rr_ptr_i};
      end
      if (prio_en_i && valid_i[0]) begin
         found = 1'b1;
      end else begin
         found = 1'b0;
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = base + 4'(k);
         if (idx >= N_REQ) begin
            idx = idx - N_REQ + {3'b000, prio_en_i};
         end else begin
            idx = idx;
         end
         hit = 1'b0;
         for (int j = 0; j < NUM_REQ; j++) begin
            if (idx == 4'(j)) begin
               hit = valid_i[j];
            end else begin
               hit = hit;
            end
         end
         if (!found && hit && !(prio_en_i && (idx == 4'd0))) begin
            winner_o = idx[2:0];
            found    = 1'b1;
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin packet scheduler sharing one UART transmitter, with burst cap and idle gap.
// Optional fixed priority for requester 0 when UART_TX_SCHED_PRIORITY_EN is defined.
module uart_tx_scheduler
   import sc64::*;
#(
   parameter int NUM_REQ   = UART_SCHED_NUM_REQ,
   parameter int MAX_BURST = UART_SCHED_MAX_BURST
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*8-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 tx_valid,
   output logic [7:0]           tx_data,
   input  logic                 tx_ready,
   output logic [2:0]           grant_id,
   output logic                 active
);

   localparam logic [3:0] N_REQ = 4'(NUM_REQ);
   localparam logic [7:0] MAX_B = 8'(MAX_BURST);
`ifdef UART_TX_SCHED_PRIORITY_EN
   localparam logic PRIO_EN = 1'b1;
`else
   localparam logic PRIO_EN = 1'b0;
`endif

   e_tx_sched_state    state_q, state_d;
   logic [2:0]         rr_ptr_q, rr_ptr_d;
   logic [2:0]         grant_id_q, grant_id_d;
   logic               active_q, active_d;
   logic               out_full_q, out_full_d;
   logic [7:0]         out_data_q, out_data_d;
   logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
   logic [7:0]         burst_cnt_q, burst_cnt_d;
   logic               last_q, last_d;

   logic [2:0]         winner_s;
   logic               any_valid_s;
   logic               req_hs_s;
   logic               tx_hs_s;
   logic               sel_last_s;
   logic [7:0]         sel_data_s;

   uart_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .valid_i     (req_valid),
      .rr_ptr_i    (rr_ptr_q),
      .prio_en_i   (PRIO_EN),
      .winner_o    (winner_s),
      .any_valid_o (any_valid_s)
   );

   // Next-state, output-register and bookkeeping logic.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_id_d  = grant_id_q;
      out_full_d  = out_full_q;
      out_data_d  = out_data_q;
      burst_cnt_d = burst_cnt_q;
      last_d      = last_q;
      sel_last_s  = 1'b0;
      sel_data_s  = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id_q == 3'(i)) begin
            sel_last_s = req_last[i];
            sel_data_s = req_data[8*i +: 8];
         end else begin
            sel_last_s = sel_last_s;
         end
      end
      req_hs_s = |(req_valid & req_ready_q);
      tx_hs_s  = out_full_q && tx_ready;

      case (state_q)
         S_IDLE: begin
            if (any_valid_s) begin
               state_d     = S_GRANT;
               grant_id_d  = winner_s;
               burst_cnt_d = 8'd0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GRANT: begin
            if (req_hs_s) begin
               out_data_d = sel_data_s;
               out_full_d = 1'b1;
               last_d     = sel_last_s;
               if (burst_cnt_q >= MAX_B) begin
                  burst_cnt_d = MAX_B;
               end else begin
                  burst_cnt_d = burst_cnt_q + 8'd1;
               end
            end else if (tx_hs_s) begin
               out_full_d = 1'b0;
               state_d    = S_GAP;
            end else begin
               state_d = S_GRANT;
            end
         end
         S_GAP: begin
            if (last_q || (burst_cnt_q == MAX_B)) begin
               rr_ptr_d = rr_next_ptr(grant_id_q, N_REQ, PRIO_EN);
               state_d  = S_IDLE;
            end else begin
               state_d = S_GRANT;
            end
         end
         default: begin
            state_d    = S_IDLE;
            out_full_d = 1'b0;
         end
      endcase

      active_d = (state_d != S_IDLE);
      // The grantee may load only while the output register is empty.
      if ((state_d == S_GRANT) && !out_full_d) begin
         req_ready_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_d;
      end else begin
         req_ready_d = {NUM_REQ{1'b0}};
      end
   end

   // State and registered outputs; reset drops any buffered byte at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= 3'd0;
         grant_id_q  <= 3'd0;
         active_q    <= 1'b0;
         out_full_q  <= 1'b0;
         out_data_q  <= 8'h00;
         req_ready_q <= {NUM_REQ{1'b0}};
         burst_cnt_q <= 8'd0;
         last_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_id_q  <= grant_id_d;
         active_q    <= active_d;
         out_full_q  <= out_full_d;
         out_data_q  <= out_data_d;
         req_ready_q <= req_ready_d;
         burst_cnt_q <= burst_cnt_d;
         last_q      <= last_d;
      end
   end

   assign req_ready = req_ready_q;
   assign tx_valid  = out_full_q;
   assign tx_data   = out_data_q;
   assign grant_id  = grant_id_q;
   assign active    = active_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler (NUM_REQ=4, MAX_BURST=4) with per-requester byte queues.
// The priority scenario runs only when UART_TX_SCHED_PRIORITY_EN is defined.
module tb_uart_tx_scheduler;
   import sc64::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        tx_ready = 1'b0;
   logic [3:0]  req_valid = 4'h0;
   logic [3:0]  req_last = 4'h0;
   logic [31:0] req_data = 32'h0;
   logic [3:0]  req_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic [2:0]  grant_id;
   logic        active;

   int total_cnt = 0;
   int bad_cnt = 0;
   int cyc = 0;

   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [8:0] q2[$];
   logic [8:0] q3[$];
   int log_data[$];
   int log_gid[$];
   int log_cyc[$];

   always #5 clk = ~clk;

   uart_tx_scheduler #(
      .NUM_REQ   (4),
      .MAX_BURST (4)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready),
      .grant_id  (grant_id),
      .active    (active)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Requesters present queue heads at negedge; handshakes are recorded just after.
   initial begin
      forever begin
         @(negedge clk);
         req_valid = 4'h0;
         req_last  = 4'h0;
         req_data  = 32'h0;
         if (q0.size() > 0) begin req_valid[0] = 1'b1; req_data[7:0]   = q0[0][7:0]; req_last[0] = q0[0][8]; end
         if (q1.size() > 0) begin req_valid[1] = 1'b1; req_data[15:8]  = q1[0][7:0]; req_last[1] = q1[0][8]; end
         if (q2.size() > 0) begin req_valid[2] = 1'b1; req_data[23:16] = q2[0][7:0]; req_last[2] = q2[0][8]; end
         if (q3.size() > 0) begin req_valid[3] = 1'b1; req_data[31:24] = q3[0][7:0]; req_last[3] = q3[0][8]; end
         #1;
         if (req_valid[0] && req_ready[0]) void'(q0.pop_front());
         if (req_valid[1] && req_ready[1]) void'(q1.pop_front());
         if (req_valid[2] && req_ready[2]) void'(q2.pop_front());
         if (req_valid[3] && req_ready[3]) void'(q3.pop_front());
         if (tx_valid && tx_ready) begin
            log_data.push_back(int'(tx_data));
            log_gid.push_back(int'(grant_id));
            log_cyc.push_back(cyc);
         end
         cyc++;
      end
   end

   task automatic clear_log();
      log_data.delete();
      log_gid.delete();
      log_cyc.delete();
   endtask

   task automatic wait_log(input int n, input int budget);
      int k;
      k = 0;
      while ((log_data.size() < n) && (k < budget)) begin
         @(posedge clk);
         k++;
      end
      if (log_data.size() < n) check_val("log_timeout", 32'(log_data.size()), 32'(n));
   endtask

   task automatic exp_entry(input string tag, input int i, input int d, input int g);
      if (i < log_data.size()) begin
         check_val(tag, 32'(log_data[i]), 32'(d));
         check_val({tag, "_gid"}, 32'(log_gid[i]), 32'(g));
      end else begin
         check_val({tag, "_missing"}, 32'(log_data.size()), 32'(i + 1));
      end
   endtask

   task automatic exp_gap(input string tag, input int i, input int g);
      if (i < log_cyc.size()) check_val(tag, 32'(log_cyc[i] - log_cyc[i-1]), 32'(g));
      else check_val({tag, "_missing"}, 32'(log_cyc.size()), 32'(i + 1));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      int k;
      int rr_d[8];
      int rr_g[8];
      int bc_d[14];
      int bc_g[14];
      rr_d = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h11, 32'h21, 32'h31, 32'h41};
      rr_g = '{0, 1, 2, 3, 0, 1, 2, 3};
      bc_d = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hB0, 32'hB1, 32'hB2, 32'hB3,
               32'hA4, 32'hA5, 32'hA6, 32'hA7, 32'hA8, 32'hA9};
      bc_g = '{1, 1, 1, 1, 3, 3, 3, 3, 1, 1, 1, 1, 1, 1};

      // Reset state
      repeat (3) @(negedge clk);
      check_val("rst_tx_valid", 32'(tx_valid), 32'd0);
      check_val("rst_tx_data", 32'(tx_data), 32'd0);
      check_val("rst_req_ready", 32'(req_ready), 32'd0);
      check_val("rst_grant_id", 32'(grant_id), 32'd0);
      check_val("rst_active", 32'(active), 32'd0);
      @(posedge clk); #3 reset_n = 1'b1;
      #1;
      check_val("rst_state", 32'(dut.state_q), 32'(S_IDLE));
      check_val("rst_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);

      // Single three-byte packet from requester 2
      @(negedge clk); tx_ready = 1'b1;
      @(posedge clk); #2;
      q2.push_back(9'h041); q2.push_back(9'h042); q2.push_back(9'h143);
      wait_log(3, 100);
      exp_entry("pkt_b0", 0, 32'h41, 2);
      exp_entry("pkt_b1", 1, 32'h42, 2);
      exp_entry("pkt_b2", 2, 32'h43, 2);
      exp_gap("pkt_gap1", 1, 3);
      exp_gap("pkt_gap2", 2, 3);
      repeat (5) @(negedge clk);
      check_val("pkt_active_after", 32'(active), 32'd0);
      check_val("pkt_rr_ptr", 32'(dut.rr_ptr_q), 32'd3);
      tx_ready = 1'b0;
      clear_log();

      // Arbitration/byte latency, then backpressure with a loaded byte
      @(posedge clk); #2;
      q1.push_back(9'h15A);
      @(negedge clk);
      @(negedge clk);
      check_val("arb_latency", 32'(req_ready), 32'h2);
      @(negedge clk);
      check_val("byte_latency", 32'(tx_valid), 32'd1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_val("bp_tx_valid", 32'(tx_valid), 32'd1);
         check_val("bp_tx_data", 32'(tx_data), 32'h5A);
         check_val("bp_req_ready", 32'(req_ready), 32'd0);
      end
      check_val("bp_no_transfer", 32'(log_data.size()), 32'd0);
      @(negedge clk); tx_ready = 1'b1;
      #2;
      check_val("bp_release_cnt", 32'(log_data.size()), 32'd1);
      exp_entry("bp_release", 0, 32'h5A, 1);
      repeat (3) @(negedge clk);
      tx_ready = 1'b0;
      clear_log();

      // Reset with a byte in the output register
      @(posedge clk); #2;
      q3.push_back(9'h077); q3.push_back(9'h178);
      k = 0;
      while (!tx_valid && (k < 50)) begin
         @(negedge clk);
         k++;
      end
      check_val("rst_mid_loaded", 32'(tx_valid), 32'd1);
      @(posedge clk); #3 reset_n = 1'b0;
      #1;
      check_val("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
      check_val("rst_mid_active", 32'(active), 32'd0);
      q0.delete(); q1.delete(); q2.delete(); q3.delete();
      clear_log();
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      #1;
      check_val("rst_mid_state", 32'(dut.state_q), 32'(S_IDLE));
      check_val("rst_mid_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
      @(negedge clk); tx_ready = 1'b1;
      repeat (10) @(negedge clk);
      check_val("rst_mid_stale", 32'(log_data.size()), 32'd0);

      // Round-robin over four requesters, two one-byte packets each
      @(posedge clk); #2;
      q0.push_back(9'h110); q0.push_back(9'h111);
      q1.push_back(9'h120); q1.push_back(9'h121);
      q2.push_back(9'h130); q2.push_back(9'h131);
      q3.push_back(9'h140); q3.push_back(9'h141);
      wait_log(8, 200);
      for (int i = 0; i < 8; i++) exp_entry($sformatf("rr_%0d", i), i, rr_d[i], rr_g[i]);
      for (int i = 1; i < 6; i++) exp_gap($sformatf("rr_gap_%0d", i), i, 4);
      repeat (4) @(negedge clk);
      clear_log();

      // Burst cap of 4: requester 1 streams 10 bytes, requester 3 a 4-byte packet
      @(posedge clk); #2;
      for (int i = 0; i < 10; i++) q1.push_back((i == 9) ? 9'h1A9 : (9'h0A0 + 9'(i)));
      q3.push_back(9'h0B0); q3.push_back(9'h0B1); q3.push_back(9'h0B2); q3.push_back(9'h1B3);
      wait_log(14, 400);
      for (int i = 0; i < 14; i++) exp_entry($sformatf("burst_%0d", i), i, bc_d[i], bc_g[i]);
      repeat (4) @(negedge clk);
      check_val("burst_idle_active", 32'(active), 32'd0);
      clear_log();

`ifdef UART_TX_SCHED_PRIORITY_EN
      // Requester 0 wins every arbitration while valid, requester 2 waits
      @(posedge clk); #2;
      q0.push_back(9'h0C0); q0.push_back(9'h1C1);
      q0.push_back(9'h0C2); q0.push_back(9'h1C3);
      q0.push_back(9'h0C4); q0.push_back(9'h1C5);
      q2.push_back(9'h0D0); q2.push_back(9'h1D1);
      wait_log(8, 300);
      exp_entry("prio_0", 0, 32'hC0, 0);
      exp_entry("prio_1", 1, 32'hC1, 0);
      exp_entry("prio_2", 2, 32'hC2, 0);
      exp_entry("prio_3", 3, 32'hC3, 0);
      exp_entry("prio_4", 4, 32'hC4, 0);
      exp_entry("prio_5", 5, 32'hC5, 0);
      exp_entry("prio_6", 6, 32'hD0, 2);
      exp_entry("prio_7", 7, 32'hD1, 2);
`endif

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Shares the single CPU UART transmitter between several byte-stream requesters, such as debug console, USB bridge logger and flash programmer trace. It sits in front of the UART TX path and grants the transmitter to one requester per packet using round-robin order. A burst cap forces rotation so that no requester can monopolise the link. Each byte goes through a one-byte output register, and an idle gap cycle follows every byte so that the UART busy flag has time to settle.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- MAX_BURST, 16: maximum bytes per grant before a forced release; legal range 1..255.

Ports:
- clk  in  1  system clock; the block has one clock.
- reset_n  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*8  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  marks the final byte of the packet; qualified by req_valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- tx_valid  out  1  byte available to the UART.
- tx_data  out  8  byte to transmit.
- tx_ready  in  1  UART TX idle; transfer occurs on tx_valid && tx_ready.
- grant_id  out  3  index of the current or last grantee.
- active  out  1  high while a grant is held.

## Operation
- State machine has three states: S_IDLE, S_GRANT and S_GAP.
- S_IDLE:
  - If any req_valid is high, the arbiter picks the winner and the block enters S_GRANT.
  - Winner search starts at rr_ptr and goes upward, wrapping from NUM_REQ-1 to 0.
  - On entry to S_GRANT: grant_id is set to the winner and burst_cnt is cleared to 0.
- S_GRANT:
  - req_ready[grant_id] = !out_full; all other req_ready bits are 0.
  - On a requester handshake: out_data <= data, out_full <= 1, last_q <= req_last, burst_cnt <= burst_cnt+1.
  - tx_valid = out_full and tx_data = out_data.
  - On tx_valid && tx_ready: out_full <= 0, then the block enters S_GAP.
- S_GAP lasts exactly one cycle. tx_valid and all req_ready bits are 0. At the end of the cycle:
  - if last_q=1 or burst_cnt==MAX_BURST: rr_ptr <= grant_id+1 (mod NUM_REQ), active <= 0, next state is S_IDLE;
  - otherwise, next state is S_GRANT with the same grantee.
- If the grantee drops req_valid mid-packet, the grant is held and the block waits. There is no timeout.
- burst_cnt is 8 bits and saturates at MAX_BURST. A forced release does not require req_last.
- With a single valid requester, the same requester is re-granted after one S_IDLE cycle.

## Timing
- Reset values: state=S_IDLE, rr_ptr=0, grant_id=0, active=0, out_full=0, tx_valid=0, tx_data=0, req_ready=0, burst_cnt=0, last_q=0.
- Outputs during reset: all outputs hold their reset values while reset_n is low.
- Reset deassertion: no requester handshake occurs before the first clk edge after reset_n rises.
- Arbitration latency: req_valid rising in S_IDLE at cycle n gives req_ready high at n+1.
- Byte latency: a requester handshake at cycle n gives tx_valid at n+1.
- Throughput: the minimum spacing between UART handshakes is 3 cycles (load, present, gap).
- Packet switch overhead: one S_GAP cycle plus one S_IDLE cycle.
- Reset mid-byte: a byte held in the output register is discarded, and tx_valid falls asynchronously.
- Simultaneous tx handshake and new req_valid on another port: the new request is honoured only after S_GAP and S_IDLE.
- tx_data is stable while tx_valid=1 && tx_ready=0.

## Configuration
- UART_TX_SCHED_PRIORITY_EN:
  - When defined: in S_IDLE, requester 0 wins whenever req_valid[0]=1. Round-robin over requesters 1..NUM_REQ-1 applies otherwise. rr_ptr never points to 0. Requester 0 is still subject to MAX_BURST.
  - When undefined: pure round-robin across all requesters.
- Preemption: there is no preemption inside a grant in either mode.

## Structure
- The shared sc64 package holds the e_tx_sched_state enum (S_IDLE, S_GRANT, S_GAP) and the defaults UART_SCHED_NUM_REQ and UART_SCHED_MAX_BURST.
- One sub-module, uart_rr_arbiter, is natural. It is combinational: inputs are the valid vector, rr_ptr and the priority option; outputs are the winner index and an any-valid flag.
- The top module owns the FSM, the output register, burst_cnt and rr_ptr.

## Test plan
- Single packet: requester 2 sends 0x41, 0x42, then 0x43 with last; tx_ready is held 1. Required response:
  - tx_data sequence is 41, 42, 43;
  - handshakes are 3 cycles apart;
  - afterwards active=0 and rr_ptr=3.
- Round-robin: all four requesters send one-byte packets continuously. Required response: grant_id order is 0, 1, 2, 3, 0, 1; each switch costs 2 idle cycles.
- Burst cap with MAX_BURST=4: requester 1 streams 10 bytes, the last byte only at the end, while requester 3 is valid. Required response: four bytes from 1, then four from 3 if its packet lasts that long, then the remainder from 1.
- Backpressure: tx_ready=0 for 20 cycles with a byte loaded. Required response:
  - tx_valid=1 and tx_data stable throughout;
  - req_ready=0 throughout;
  - the byte transfers on the first tx_ready=1.
- Reset mid-packet: reset_n is pulled low while out_full=1. Required response: tx_valid=0 immediately; after release, the FSM is in S_IDLE, rr_ptr=0 and the stale byte is never sent.
- Priority with UART_TX_SCHED_PRIORITY_EN defined: requesters 0 and 2 are valid simultaneously, and requester 0 sends a 2-byte packet three times. Required response: each packet from 0 wins; requester 2 is granted only when req_valid[0]=0 at S_IDLE.
